// File: rtl/reset_sequencer.sv
// reset_sequencer: resynchronises the board reset, holds clear for a fixed window, then enables a
// downstream async-clear flop bank; replays the same sequence on a software request with req/ack.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int CLR_CYCLES  = 16,
    parameter int EN_DELAY    = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       soft_rst_req,
    output logic       soft_rst_ack,
    output logic       clr_o,
    output logic       ce_o,
    output logic       ready_o,
    output logic [1:0] state_o
);
    typedef enum logic [1:0] {
        ST_RESET   = 2'b00,
        ST_CLEAR   = 2'b01,
        ST_WAIT_EN = 2'b10,
        ST_RUN     = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] EN_LOAD  = CNT_W'((EN_DELAY > 0) ? EN_DELAY - 1 : 0);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_dec;
    logic                   released;
    logic                   pending_q, pending_d;
    logic                   ack_q, ack_d;
    logic                   clr_q, clr_d;
    logic                   ce_q, ce_d;
    logic                   ready_q, ready_d;

    assign released = sync_q[SYNC_STAGES-1];
    // Counter saturates at zero; it only moves off zero through a load on state entry.
    assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], 1'b1};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_dec;
        pending_d = pending_q;
        ack_d     = 1'b0;
        case (state_q)
            ST_RESET: begin
                cnt_d = '0;
                if (released) begin
                    state_d = ST_CLEAR;
                    cnt_d   = CLR_LOAD;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == '0) begin
                    if (EN_DELAY == 0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_WAIT_EN;
                        cnt_d   = EN_LOAD;
                    end
                end
            end
            ST_WAIT_EN: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (soft_rst_req) begin
                    state_d   = ST_CLEAR;
                    cnt_d     = CLR_LOAD;
                    pending_d = 1'b1;
                end
            end
            default: state_d = ST_RESET;
        endcase

        // Ack coincides with the edge that re-enters RUN, i.e. the edge ce_o rises.
        if (state_d == ST_RUN && state_q != ST_RUN) begin
            ack_d     = pending_q;
            pending_d = 1'b0;
        end

        // Outputs decode the next state so they are flop outputs, never combinational.
        clr_d   = (state_d == ST_RESET) || (state_d == ST_CLEAR);
        ce_d    = (state_d == ST_RUN);
        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q    <= '0;
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            clr_q     <= 1'b1;
            ce_q      <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            clr_q     <= clr_d;
            ce_q      <= ce_d;
            ready_q   <= ready_d;
        end
    end

    assign soft_rst_ack = ack_q;
    assign clr_o        = clr_q;
    assign ce_o         = ce_q;
    assign ready_o      = ready_q;
    assign state_o      = state_q;

endmodule
